// File: rtl/nn_pkg.sv
// nn_pkg: shared types and width helpers for the time-multiplexed NN layer.
package nn_pkg;

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} nn_state_t;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic int nn_one(input int frac_w);
        return 1 << frac_w;
    endfunction

    // Accumulator width: full product plus headroom for N_IN products and the bias.
    function automatic int nn_acc_w(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in + 2);
    endfunction

    // clog2 that never returns zero, so every index/address bus has at least one bit.
    function automatic int nn_clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/nn_layer_seq_if.sv
// nn_layer_seq_if: weight-write port plus input/output valid-ready streams of one layer.
import nn_pkg::*;

interface nn_layer_seq_if #(
    parameter int DATA_W = 17,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int AW     = nn_clog2_min1(N_OUT * (N_IN + 1))
);
    logic                      w_we;
    logic [AW-1:0]             w_addr;
    logic [DATA_W-1:0]         w_data;
    logic                      w_busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN*DATA_W-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*DATA_W-1:0]   out_data;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_data, out_ready,
        input  w_busy, in_ready, out_valid, out_data
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
        output w_busy, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/nn_layer_act.sv
// nn_layer_act: accumulator -> output sample. Drops FRAC_W fraction bits,
// saturates to DATA_W, then applies the activation.
// Build option NN_LAYER_SIGMOID_EN selects the hard sigmoid; otherwise the
// output is the saturated linear value.
import nn_pkg::*;

module nn_layer_act #(
    parameter int DATA_W = 17,
    parameter int FRAC_W = 11,
    parameter int ACC_W  = 36
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);
    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    logic signed [ACC_W-1:0]  s_full;
    logic signed [DATA_W-1:0] s_sat;

    assign s_full = acc >>> FRAC_W;

    // Clamp the rescaled sum into the DATA_W two's-complement range.
    always_comb begin
        if (s_full > S_MAX)
            s_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (s_full < S_MIN)
            s_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            s_sat = s_full[DATA_W-1:0];
    end

`ifdef NN_LAYER_SIGMOID_EN
    localparam logic signed [DATA_W+1:0] HALF = (DATA_W+2)'(nn_one(FRAC_W) / 2);
    localparam logic signed [DATA_W+1:0] ONE  = (DATA_W+2)'(nn_one(FRAC_W));

    logic signed [DATA_W+1:0] t;

    // Hard sigmoid: s/4 + 0.5, clamped to [0, 1.0]; two guard bits keep the sum exact.
    always_comb begin
        t = ($signed({{2{s_sat[DATA_W-1]}}, s_sat}) >>> 2) + HALF;
        if (t[DATA_W+1])
            y = '0;
        else if (t > ONE)
            y = ONE[DATA_W-1:0];
        else
            y = t[DATA_W-1:0];
    end
`else
    assign y = s_sat;
`endif

endmodule

// File: rtl/nn_layer_seq.sv
// nn_layer_seq: one signed MAC evaluates N_OUT neurons of N_IN inputs each,
// one product per cycle, with run-time loadable weights/biases.
// Build option NN_LAYER_SIGMOID_EN (in nn_layer_act) enables the hard sigmoid.
import nn_pkg::*;

module nn_layer_seq #(
    parameter int DATA_W = 17,
    parameter int FRAC_W = 11,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    nn_layer_seq_if.slave bus
);
    localparam int NW    = N_OUT * (N_IN + 1);
    localparam int AW    = nn_clog2_min1(NW);
    localparam int ACC_W = nn_acc_w(DATA_W, N_IN);
    localparam int IW    = nn_clog2_min1(NW + N_IN + 2);
    localparam int NI_W  = nn_clog2_min1(N_IN);
    localparam int NO_W  = nn_clog2_min1(N_OUT);

    nn_state_t                      state;
    logic [N_IN-1:0][DATA_W-1:0]    x_q;
    logic [NW-1:0][DATA_W-1:0]      w_mem;
    logic [N_OUT-1:0][DATA_W-1:0]   y_buf;
    logic [N_OUT-1:0][DATA_W-1:0]   out_q;
    logic                           out_valid_q;
    logic signed [ACC_W-1:0]        acc;
    logic [NI_W-1:0]                i_idx;
    logic [NO_W-1:0]                n_idx;
    logic [IW-1:0]                  base;      // n*(N_IN+1): first weight of neuron n
    logic                           pend_we;   // write that arrived with an input accept
    logic [AW-1:0]                  pend_addr;
    logic [DATA_W-1:0]              pend_data;

    logic [IW-1:0]                  w_idx;
    logic [IW-1:0]                  nb_idx;
    logic signed [DATA_W-1:0]       w_cur;
    logic signed [DATA_W-1:0]       x_cur;
    logic [DATA_W-1:0]              b_next;
    logic signed [2*DATA_W-1:0]     prod;
    logic signed [DATA_W-1:0]       y_new;

    function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic [DATA_W-1:0] b);
        return $signed({{(ACC_W-DATA_W){b[DATA_W-1]}}, b}) <<< FRAC_W;
    endfunction

    assign w_idx  = base + IW'(i_idx);
    assign nb_idx = base + IW'(2 * N_IN + 1);

    // Operand fetch for the current MAC step and next neuron's bias; the
    // bias index runs past the table on the last neuron, where it is unused.
    always_comb begin
        w_cur  = (w_idx  < IW'(NW)) ? w_mem[w_idx[AW-1:0]]  : '0;
        b_next = (nb_idx < IW'(NW)) ? w_mem[nb_idx[AW-1:0]] : '0;
        x_cur  = x_q[i_idx];
        prod   = w_cur * x_cur;
    end

    nn_layer_act #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_act (
        .acc (acc),
        .y   (y_new)
    );

    // Control FSM, datapath registers and weight store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_q         <= '0;
            w_mem       <= '0;
            y_buf       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            acc         <= '0;
            i_idx       <= '0;
            n_idx       <= '0;
            base        <= '0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.w_we && int'(bus.w_addr) < NW) begin
                        // A write alongside an accept is held back so this vector sees old weights.
                        if (bus.in_valid) begin
                            pend_we   <= 1'b1;
                            pend_addr <= bus.w_addr;
                            pend_data <= bus.w_data;
                        end else begin
                            w_mem[bus.w_addr] <= bus.w_data;
                        end
                    end
                    if (bus.in_valid) begin
                        x_q   <= bus.in_data;
                        n_idx <= '0;
                        i_idx <= '0;
                        base  <= '0;
                        acc   <= bias_to_acc(w_mem[AW'(N_IN)]);
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
                    if (i_idx == NI_W'(N_IN - 1))
                        state <= ACT;
                    else
                        i_idx <= i_idx + 1'b1;
                end
                ACT: begin
                    y_buf[n_idx] <= y_new;
                    if (n_idx == NO_W'(N_OUT - 1)) begin
                        // Publish the whole vector at once so out_data never shows a mix.
                        out_q            <= y_buf;
                        out_q[N_OUT-1]   <= y_new;
                        out_valid_q      <= 1'b1;
                        state            <= DONE;
                    end else begin
                        n_idx <= n_idx + 1'b1;
                        i_idx <= '0;
                        base  <= base + IW'(N_IN + 1);
                        acc   <= bias_to_acc(b_next);
                        state <= MAC;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                        if (pend_we) begin
                            w_mem[pend_addr] <= pend_data;
                            pend_we          <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.w_busy    = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq: directed checks of the 2-in/2-out layer in Q5.11.
// Expected values depend on NN_LAYER_SIGMOID_EN.
module tb_nn_layer_seq;
    localparam int DATA_W = 17;
    localparam int FRAC_W = 11;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;

`ifdef NN_LAYER_SIGMOID_EN
    localparam int E_ZERO = 1024;
    localparam int E_NOM0 = 1536;
    localparam int E_NOM1 = 768;
    localparam int E_SATP = 2048;
    localparam int E_SATN = 0;
    int se0[4] = '{512, 1024, 1024, 1536};
    int se1[4] = '{1792, 1280, 1280, 768};
`else
    localparam int E_ZERO = 0;
    localparam int E_NOM0 = 2048;
    localparam int E_NOM1 = -1024;
    localparam int E_SATP = 65535;
    localparam int E_SATN = -65536;
    int se0[4] = '{-2048, 0, 0, 2048};
    int se1[4] = '{3072, 1024, 1024, -1024};
`endif
    int sx0[4] = '{0, 0, 2048, 2048};
    int sx1[4] = '{0, 2048, 0, 2048};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    nn_layer_seq_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .AW(3)) bus();

    nn_layer_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic write_w(input int addr, input int data);
        bus.w_we   = 1'b1;
        bus.w_addr = 3'(addr);
        bus.w_data = 17'(data);
        @(posedge clk); #1;
        bus.w_we   = 1'b0;
    endtask

    task automatic load_xor();
        write_w(0, 2048);  write_w(1, 2048);  write_w(2, -2048);
        write_w(3, -2048); write_w(4, -2048); write_w(5, 3072);
    endtask

    // Send one vector from IDLE, wait for the result, then take it.
    task automatic run_vec(input int x0, input int x1, output int y0, output int y1, output int lat);
        bus.in_data  = {17'(x1), 17'(x0)};
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        y0 = int'($signed(bus.out_data[DATA_W-1:0]));
        y1 = int'($signed(bus.out_data[2*DATA_W-1:DATA_W]));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int y0, y1, lat;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h want 0", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.w_busy !== 1'b0) begin errors++; $display("FAIL reset_w_busy got %0b want 0", bus.w_busy); end
        run_vec(2048, 2048, y0, y1, lat);
        checks++; if (y0 !== E_ZERO || y1 !== E_ZERO) begin errors++; $display("FAIL reset_zero_weights got %0d,%0d want %0d,%0d", y0, y1, E_ZERO, E_ZERO); end
    endtask

    task automatic test_nominal();
        int y0, y1, lat;
        load_xor();
        run_vec(2048, 2048, y0, y1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL nominal_latency got %0d want 6", lat); end
        checks++; if (y0 !== E_NOM0) begin errors++; $display("FAIL nominal_y0 got %0d want %0d", y0, E_NOM0); end
        checks++; if (y1 !== E_NOM1) begin errors++; $display("FAIL nominal_y1 got %0d want %0d", y1, E_NOM1); end
    endtask

    task automatic test_saturation();
        int y0, y1, lat;
        write_w(0, 65535); write_w(1, 65535); write_w(2, 65535);
        run_vec(65535, 65535, y0, y1, lat);
        checks++; if (y0 !== E_SATP) begin errors++; $display("FAIL sat_pos_y0 got %0d want %0d", y0, E_SATP); end
        write_w(0, -65536); write_w(1, -65536); write_w(2, -65536);
        run_vec(65535, 65535, y0, y1, lat);
        checks++; if (y0 !== E_SATN) begin errors++; $display("FAIL sat_neg_y0 got %0d want %0d", y0, E_SATN); end
    endtask

    task automatic test_backpressure();
        int y0, y1, lat, extra;
        logic [N_OUT*DATA_W-1:0] held;
        load_xor();
        bus.in_data  = {17'(2048), 17'(2048)};
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 6) begin errors++; $display("FAIL bp_latency got %0d want 6", lat); end
        held = bus.out_data;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.w_we = 1'b1; bus.w_addr = 3'd2; bus.w_data = '0;
            end
            @(posedge clk); #1;
            bus.w_we = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d got v=%0b d=%0h rdy=%0b want v=1 d=%0h rdy=0", c, bus.out_valid, bus.out_data, bus.in_ready, held);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL bp_single_transfer got %0d want 0", extra); end
        run_vec(2048, 2048, y0, y1, lat);
        checks++; if (y0 !== E_NOM0) begin errors++; $display("FAIL bp_write_ignored got %0d want %0d", y0, E_NOM0); end
    endtask

    task automatic test_reset_mid();
        int y0, y1, lat, seen;
        load_xor();
        bus.in_data  = {17'(2048), 17'(2048)};
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid got %0d want 0", seen); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL midrst_out_data got %0h want 0", bus.out_data); end
        run_vec(2048, 2048, y0, y1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL midrst_latency got %0d want 6", lat); end
        checks++; if (y0 !== E_ZERO || y1 !== E_ZERO) begin errors++; $display("FAIL midrst_weights_cleared got %0d,%0d want %0d,%0d", y0, y1, E_ZERO, E_ZERO); end
    endtask

    task automatic test_streaming();
        int ry0[8], ry1[8], rc[8];
        int nres, cyc, g;
        nres = 0;
        cyc  = 0;
        load_xor();
        bus.out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    bus.in_data  = {17'(sx1[k]), 17'(sx0[k])};
                    bus.in_valid = 1'b1;
                    g = 0;
                    while (!bus.in_ready && g < 100) begin
                        @(posedge clk); #1;
                        g++;
                    end
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (bus.out_valid) begin
                        if (nres < 8) begin
                            ry0[nres] = int'($signed(bus.out_data[DATA_W-1:0]));
                            ry1[nres] = int'($signed(bus.out_data[2*DATA_W-1:DATA_W]));
                            rc[nres]  = cyc;
                        end
                        nres++;
                    end
                end
            end
        join
        bus.out_ready = 1'b0;
        checks++; if (nres !== 4) begin errors++; $display("FAIL stream_count got %0d want 4", nres); end
        for (int k = 0; k < 4 && k < nres; k++) begin
            checks++;
            if (ry0[k] !== se0[k] || ry1[k] !== se1[k]) begin
                errors++;
                $display("FAIL stream_result k=%0d got %0d,%0d want %0d,%0d", k, ry0[k], ry1[k], se0[k], se1[k]);
            end
        end
        for (int k = 1; k < 4 && k < nres; k++) begin
            checks++;
            if (rc[k] - rc[k-1] !== 8) begin errors++; $display("FAIL stream_spacing k=%0d got %0d want 8", k, rc[k] - rc[k-1]); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Parametrised, time-multiplexed fully-connected neural-network layer. It replaces the fixed-weight, fully-unrolled XOR network. A single signed multiply-accumulator evaluates N_OUT neurons of N_IN inputs each, with run-time-loadable weights and biases. An optional hard-sigmoid activation follows the accumulator. Layers chain through valid/ready handshakes; a 2-2-1 XOR net is two instances.

## Interface
- DATA_W, 17: data, weight and bias width; two's complement.
- FRAC_W, 11: fractional bits; 1.0 = 2^FRAC_W.
- N_IN, 2: inputs per neuron; must be ≥1.
- N_OUT, 2: neurons; must be ≥1.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_we  in  1  weight/bias write strobe.
- w_addr  in  clog2(N_OUT*(N_IN+1))  address = n*(N_IN+1)+j; j==N_IN selects the bias of neuron n.
- w_data  in  DATA_W  value to write.
- w_busy  out  1  high when not IDLE; writes are ignored while high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  N_IN*DATA_W  x[i] at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  N_OUT*DATA_W  y[n] at bits [n*DATA_W +: DATA_W].

## Operation
- States: IDLE, MAC, ACT, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: latch in_data, set n=0 and i=0, load acc = bias[0] sign-extended and shifted left by FRAC_W, then go to MAC.
- **MAC:**
  - Each cycle: acc += w[n][i]*x[i], i++.
  - The cycle that adds i==N_IN-1 moves to ACT.
- **ACT:**
  - Compute s = acc >>> FRAC_W (arithmetic), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Write y[n] = act(s).
  - If n==N_OUT-1, go to DONE. Otherwise n++, i=0, acc = bias[n+1]<<FRAC_W, and go to MAC.
- **DONE:**
  - out_valid=1.
  - On out_ready, go to IDLE. in_ready rises the next cycle; no bypass.
- Arithmetic:
  - Products are 2*DATA_W bits.
  - acc is ACC_W = 2*DATA_W + clog2(N_IN+2) bits. The accumulator never overflows; saturation happens only at ACT.
- Weight writes:
  - Accepted only in IDLE and take effect the next cycle.
  - Out-of-range w_addr is ignored.
  - A write coincident with an input accept is applied, but the current vector uses the old value.
- out_data:
  - Holds the last completed vector until the next DONE.
  - A partially updated out_data is never exposed while out_valid=1.
- Reset:
  - State=IDLE, out_valid=0, out_data=0, all weights/biases=0, acc=0, w_busy=0, in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards the vector; no out_valid is produced.

## Timing
- Input accept edge to out_valid high: exactly N_OUT*(N_IN+1) cycles. This is 6 for the defaults.
- Throughput: one vector per N_OUT*(N_IN+1)+2 cycles with out_ready held high.
- out_valid and out_data are registered outputs. in_ready and w_busy decode the state register only.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- NN_LAYER_SIGMOID_EN defined:
  - act(s) = clamp((s>>>2) + 2^(FRAC_W-1), 0, 2^FRAC_W).
  - This is a hard sigmoid, so outputs lie in [0, 1.0].
- Not defined:
  - act(s) = s, a saturated linear output.
  - The ACT state and its cycle count are unchanged, so latency is identical in both builds.

## Structure
- Package nn_pkg holds:
  - state enum nn_state_t {IDLE, MAC, ACT, DONE}.
  - function nn_one(FRAC_W).
  - the ACC_W derivation function.
- Sub-module nn_layer_act: combinational shift, saturation and activation, with DATA_W/FRAC_W/ACC_W parameters. It is shared by the other layer variants.
- The weight store is a flat register array in nn_layer_seq; no RAM macro.

## Test plan
All scenarios use the defaults (Q5.11; 1.0 = 2048).
- **Reset:** assert rst 2 cycles → out_valid=0, out_data=0, in_ready=1, w_busy=0; a vector sent with no weights loaded yields y={1024,1024} with SIGMOID_EN, {0,0} without.
- **Nominal:** load w0={2048,2048}, b0=-2048, w1={-2048,-2048}, b1=3072; send x={2048,2048} → out_valid exactly 6 cycles after accept, y={1536,768} with SIGMOID_EN, {2048,-1024} without.
- **Saturation:** load w0={65535,65535}, b0=65535; send x={65535,65535} → y0=2048 (sigmoid) or 65535 (linear); with weights -65536 → y0=0 or -65536.
- **Backpressure:** hold out_ready=0 for 10 cycles → out_valid stays 1, out_data is stable, in_ready=0, and a w_we pulse is ignored (a readback vector shows the old weight); release → exactly one transfer, in_ready=1 the next cycle.
- **Reset mid-op:** assert rst in the 3rd MAC cycle → no out_valid follows, out_data=0, weights cleared; the next vector completes normally.
- **Streaming:** 4 back-to-back vectors (all XOR input pairs) with out_ready=1 → results spaced 8 cycles apart, match the reference model, none dropped or duplicated.
